// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the L1 data-cache controller and its tag memory:
// geometry constants, the tag-memory request/tag structs, the controller
// FSM state encoding and a helper that rebuilds a line-aligned address.
package cache_ctrl_pkg;

    localparam int CC_ADDR_W   = 32;
    localparam int CC_INDEX_W  = 8;
    localparam int CC_OFFSET_W = 4;
    localparam int CC_TAG_W    = CC_ADDR_W - CC_INDEX_W - CC_OFFSET_W;
    localparam int LINE_WORDS  = 4;
    localparam int BEAT_W      = 2;

    typedef struct packed {
        logic [CC_INDEX_W-1:0] index;
        logic                  wr_en;
    } cache_req_t;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [CC_TAG_W-1:0] tag;
    } cache_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_WB_REQ   = 3'd2,
        ST_WB       = 3'd3,
        ST_FILL_REQ = 3'd4,
        ST_FILL     = 3'd5,
        ST_UPDATE   = 3'd6,
        ST_RESP     = 3'd7
    } cache_state_e;

    // Line-aligned byte address built from a tag and an index.
    function automatic logic [CC_ADDR_W-1:0] line_addr(
        input logic [CC_TAG_W-1:0]   tag,
        input logic [CC_INDEX_W-1:0] index
    );
        return {tag, index, {CC_OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_beat_cnt.sv
// Two-bit burst beat counter shared by the writeback and fill phases.
// Clear restarts at beat 0; the counter wraps to 0 after the fourth beat,
// and last_o flags the increment that completes the burst.
module cache_beat_cnt
    import cache_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] cnt_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] cnt_r;

    // Beat count register: clear has priority, otherwise count accepted beats.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= 2'd0;
        end else if (clr_i) begin
            cnt_r <= 2'd0;
        end else if (inc_i) begin
            cnt_r <= cnt_r + 2'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o  = cnt_r;
    assign last_o = inc_i && (cnt_r == 2'd3);

endmodule

// File: rtl/cache_ctrl.sv
// L1 direct-mapped data-cache controller (write-back, write-allocate).
// Owns the tag path, decides hit/miss and sequences the dirty writeback and
// line-fill bursts. Optional build macro CACHE_STATS_EN adds saturating
// hit_cnt_o / miss_cnt_o response counters.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = CC_ADDR_W,
    parameter int INDEX_W  = CC_INDEX_W,
    parameter int OFFSET_W = CC_OFFSET_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_valid_i,
    output logic              cpu_req_ready_o,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_we_i,
    output logic              cpu_resp_valid_o,
    output logic              cpu_hit_o,
    output cache_req_t        cache_req_o,
    output cache_tag_t        wr_tag_o,
    input  cache_tag_t        rd_tag_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_beat_i,
    output logic [1:0]        dmem_word_o,
    output logic              dmem_fill_we_o
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    cache_state_e       state_r, next_state_s;
    logic [TAG_W-1:0]   tag_r;
    logic [INDEX_W-1:0] index_r;
    logic               we_r;
    logic [TAG_W-1:0]   victim_tag_r;
    logic               hit_r;

    logic               lookup_hit_s;
    logic               lookup_victim_s;
    logic               beat_clr_s, beat_inc_s, beat_last_s;
    logic [1:0]         beat_cnt_s;

    logic               ready_s, resp_valid_s, resp_hit_s;
    cache_req_t         cache_req_s;
    cache_tag_t         wr_tag_s;
    logic               mem_valid_s, mem_we_s;
    logic [ADDR_W-1:0]  mem_addr_s;
    logic [1:0]         dmem_word_s;
    logic               fill_we_s;

    // Byte offset is irrelevant to a line-granular controller.
    logic               unused_offset_s;
    assign unused_offset_s = ^cpu_addr_i[OFFSET_W-1:0];

    assign lookup_hit_s    = rd_tag_i.valid && (rd_tag_i.tag == tag_r);
    assign lookup_victim_s = !lookup_hit_s && rd_tag_i.valid && rd_tag_i.dirty;

    // Beats only count inside a burst; the command cycle clears the counter,
    // so a beat coincident with command acceptance is not counted.
    assign beat_clr_s = (state_r == ST_WB_REQ) || (state_r == ST_FILL_REQ);
    assign beat_inc_s = mem_beat_i && ((state_r == ST_WB) || (state_r == ST_FILL));

    cache_beat_cnt u_beat_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (beat_clr_s),
        .inc_i  (beat_inc_s),
        .cnt_o  (beat_cnt_s),
        .last_o (beat_last_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture: address/we at acceptance, victim tag and hit at lookup.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_r        <= '0;
            index_r      <= '0;
            we_r         <= 1'b0;
            victim_tag_r <= '0;
            hit_r        <= 1'b0;
        end else begin
            if ((state_r == ST_IDLE) && cpu_req_valid_i) begin
                tag_r   <= cpu_addr_i[ADDR_W-1 -: TAG_W];
                index_r <= cpu_addr_i[OFFSET_W +: INDEX_W];
                we_r    <= cpu_we_i;
            end
            if (state_r == ST_LOOKUP) begin
                hit_r <= lookup_hit_s;
                if (lookup_victim_s) begin
                    victim_tag_r <= rd_tag_i.tag;
                end
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state_s      = state_r;
        ready_s           = 1'b0;
        resp_valid_s      = 1'b0;
        resp_hit_s        = 1'b0;
        cache_req_s.index = index_r;
        cache_req_s.wr_en = 1'b0;
        wr_tag_s          = '0;
        mem_valid_s       = 1'b0;
        mem_we_s          = 1'b0;
        mem_addr_s        = '0;
        dmem_word_s       = 2'd0;
        fill_we_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s           = 1'b1;
                cache_req_s.index = cpu_addr_i[OFFSET_W +: INDEX_W];
                if (cpu_req_valid_i) begin
                    next_state_s = ST_LOOKUP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit_s) begin
                    if (we_r) begin
                        cache_req_s.wr_en = 1'b1;
                        wr_tag_s          = '{valid: 1'b1, dirty: 1'b1, tag: tag_r};
                    end else begin
                        cache_req_s.wr_en = 1'b0;
                    end
                    next_state_s = ST_RESP;
                end else if (lookup_victim_s) begin
                    next_state_s = ST_WB_REQ;
                end else begin
                    next_state_s = ST_FILL_REQ;
                end
            end
            ST_WB_REQ: begin
                mem_valid_s = 1'b1;
                mem_we_s    = 1'b1;
                mem_addr_s  = line_addr(victim_tag_r, index_r);
                if (mem_req_ready_i) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_WB_REQ;
                end
            end
            ST_WB: begin
                dmem_word_s = beat_cnt_s;
                if (beat_last_s) begin
                    next_state_s = ST_FILL_REQ;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_FILL_REQ: begin
                mem_valid_s = 1'b1;
                mem_we_s    = 1'b0;
                mem_addr_s  = line_addr(tag_r, index_r);
                if (mem_req_ready_i) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_FILL_REQ;
                end
            end
            ST_FILL: begin
                dmem_word_s = beat_cnt_s;
                fill_we_s   = mem_beat_i;
                if (beat_last_s) begin
                    next_state_s = ST_UPDATE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_UPDATE: begin
                cache_req_s.wr_en = 1'b1;
                wr_tag_s          = '{valid: 1'b1, dirty: we_r, tag: tag_r};
                next_state_s      = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_s = 1'b1;
                resp_hit_s   = hit_r;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // While reset is held every output is forced low, including the IDLE
    // ready and the pass-through index.
    assign cpu_req_ready_o  = rst_i ? 1'b0 : ready_s;
    assign cpu_resp_valid_o = rst_i ? 1'b0 : resp_valid_s;
    assign cpu_hit_o        = rst_i ? 1'b0 : resp_hit_s;
    assign cache_req_o      = rst_i ? '0   : cache_req_s;
    assign wr_tag_o         = rst_i ? '0   : wr_tag_s;
    assign mem_req_valid_o  = rst_i ? 1'b0 : mem_valid_s;
    assign mem_req_we_o     = rst_i ? 1'b0 : mem_we_s;
    assign mem_req_addr_o   = rst_i ? '0   : mem_addr_s;
    assign dmem_word_o      = rst_i ? 2'd0 : dmem_word_s;
    assign dmem_fill_we_o   = rst_i ? 1'b0 : fill_we_s;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating hit/miss counters, bumped once per completed response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (state_r == ST_RESP) begin
            if (hit_r) begin
                if (hit_cnt_r != 32'hFFFF_FFFF) begin
                    hit_cnt_r <= hit_cnt_r + 32'd1;
                end
            end else begin
                if (miss_cnt_r != 32'hFFFF_FFFF) begin
                    miss_cnt_r <= miss_cnt_r + 32'd1;
                end
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: models the tag memory as the
// environment, keeps a line-state reference model of the cache policy and
// drives directed plus randomized load/store traffic with random command
// waits and beat gaps.
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cpu_req_valid_i, cpu_req_ready_o, cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_resp_valid_o, cpu_hit_o;
    cache_req_t  cache_req_o;
    cache_tag_t  wr_tag_o, rd_tag_i;
    logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic        mem_beat_i;
    logic [1:0]  dmem_word_o;
    logic        dmem_fill_we_o;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    // reference model of line state and response statistics
    bit          m_valid [256];
    bit          m_dirty [256];
    logic [19:0] m_tag   [256];
    int          m_hits = 0;
    int          m_misses = 0;

    always #5 clk_i = ~clk_i;

    cache_ctrl dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .cpu_req_valid_i (cpu_req_valid_i),
        .cpu_req_ready_o (cpu_req_ready_o),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_resp_valid_o(cpu_resp_valid_o),
        .cpu_hit_o       (cpu_hit_o),
        .cache_req_o     (cache_req_o),
        .wr_tag_o        (wr_tag_o),
        .rd_tag_i        (rd_tag_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_beat_i      (mem_beat_i),
        .dmem_word_o     (dmem_word_o),
        .dmem_fill_we_o  (dmem_fill_we_o)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
`endif
    );

    // Environment tag memory: async read, clocked write, valids cleared by reset.
    cache_tag_t tmem [256];
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) tmem[i].valid <= 1'b0;
        end else if (cache_req_o.wr_en) begin
            tmem[cache_req_o.index] <= wr_tag_o;
        end
    end
    assign rd_tag_i = tmem[cache_req_o.index];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 20'h0;
        end
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Reset in the middle of a burst: everything drops at once, no response.
    task automatic do_abort();
        @(posedge clk_i);
        #2;
        rst_i      = 1'b1;
        mem_beat_i = 1'b0;
        #1;
        chk("abort_ready", cpu_req_ready_o, 1'b0);
        chk("abort_resp", cpu_resp_valid_o, 1'b0);
        chk("abort_cmd_valid", mem_req_valid_o, 1'b0);
        chk("abort_fill_we", dmem_fill_we_o, 1'b0);
        chk("abort_word", dmem_word_o, 2'd0);
        chk("abort_req", cache_req_o, '0);
        clear_model();
`ifdef CACHE_STATS_EN
        chk("abort_hit_cnt", hit_cnt_o, 32'd0);
        chk("abort_miss_cnt", miss_cnt_o, 32'd0);
`endif
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("post_abort_ready", cpu_req_ready_o, 1'b1);
            chk("post_abort_resp", cpu_resp_valid_o, 1'b0);
            chk("post_abort_cmd", mem_req_valid_o, 1'b0);
        end
    endtask

    // One CPU transaction. fixed_wait<0 picks random command waits;
    // abort_beats>=0 resets the design after that many fill/wb beats.
    task automatic run_txn(input logic [31:0] addr, input logic we,
                           input int fixed_wait, input int abort_beats);
        logic [7:0]  idx;
        logic [19:0] tg;
        bit          exp_hit, done, beat;
        logic [32:0] cmds[$];
        logic [32:0] cur;
        int          s, phase, next_cmd_s, resp_s, upd_s, acc_s, wait_left, beats, guard;
        idx     = addr[11:4];
        tg      = addr[31:12];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        cur     = '0;
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) cmds.push_back({1'b1, m_tag[idx], idx, 4'h0});
            cmds.push_back({1'b0, tg, idx, 4'h0});
        end
        @(negedge clk_i);
        guard = 0;
        while (!cpu_req_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        chk("req_ready", cpu_req_ready_o, 1'b1);
        cpu_req_valid_i = 1'b1;
        cpu_addr_i      = addr;
        cpu_we_i        = we;
        resp_s     = exp_hit ? 2 : -1;
        next_cmd_s = exp_hit ? -1 : 2;
        upd_s = -1; acc_s = -1; phase = 0; done = 1'b0; wait_left = 0; beats = 0;
        for (s = 1; s <= 300 && !done; s++) begin
            @(negedge clk_i);
            cpu_req_valid_i = 1'b0;
            cpu_addr_i      = $urandom;
            cpu_we_i        = 1'($urandom_range(0, 1));
            mem_req_ready_i = 1'b0;
            mem_beat_i      = 1'b0;
            if (s == 1) begin
                chk("lookup_wr_en", cache_req_o.wr_en, exp_hit && we);
                if (exp_hit && we) chk("lookup_wr_tag", wr_tag_o, {1'b1, 1'b1, tg});
            end
            if (s == upd_s) begin
                chk("update_wr_en", cache_req_o.wr_en, 1'b1);
                chk("update_wr_tag", wr_tag_o, {1'b1, we, tg});
                chk("update_index", cache_req_o.index, idx);
            end
            chk("resp_valid", cpu_resp_valid_o, s == resp_s);
            if (s == resp_s) begin
                chk("resp_hit", cpu_hit_o, exp_hit);
                done = 1'b1;
            end
            if (phase == 0 || phase == 3) begin
                chk("cmd_valid_idle", mem_req_valid_o, s == next_cmd_s);
                if (s == next_cmd_s) begin
                    cur       = cmds.pop_front();
                    phase     = 1;
                    wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                end else begin
                    mem_beat_i = 1'($urandom_range(0, 1));
                end
            end
            if (phase == 1) begin
                chk("cmd_valid", mem_req_valid_o, 1'b1);
                chk("cmd_we", mem_req_we_o, cur[32]);
                chk("cmd_addr", mem_req_addr_o, cur[31:0]);
                mem_beat_i = 1'($urandom_range(0, 1));
                if (wait_left == 0) begin
                    mem_req_ready_i = 1'b1;
                    phase = 2; beats = 0; acc_s = s;
                end else begin
                    wait_left--;
                end
            end else if (phase == 2 && s > acc_s) begin
                beat       = 1'($urandom_range(0, 1));
                mem_beat_i = beat;
                #1;
                chk("fill_we", dmem_fill_we_o, beat && !cur[32]);
                if (beat) begin
                    chk("dmem_word", dmem_word_o, beats[1:0]);
                    beats++;
                    if (abort_beats >= 0 && beats == abort_beats) begin
                        do_abort();
                        return;
                    end
                    if (beats == 4) begin
                        if (cmds.size() > 0) begin
                            next_cmd_s = s + 1;
                            phase = 0;
                        end else begin
                            upd_s  = s + 1;
                            resp_s = s + 2;
                            phase  = 3;
                        end
                    end
                end
            end
        end
        mem_req_ready_i = 1'b0;
        mem_beat_i      = 1'b0;
        if (!done) chk("resp_timeout", 1'b0, 1'b1);
        if (exp_hit) begin
            m_hits++;
            if (we) m_dirty[idx] = 1'b1;
        end else begin
            m_misses++;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = we;
            m_tag[idx]   = tg;
        end
        chk("tag_mem", tmem[idx], {1'b1, m_dirty[idx], m_tag[idx]});
    endtask

    logic [19:0] r_tags [4];
    logic [7:0]  r_idxs [4];

    initial begin
        r_tags = '{20'h00001, 20'h00005, 20'h00007, 20'h0000A};
        r_idxs = '{8'h23, 8'h24, 8'hFF, 8'h00};
        rst_i = 1'b1;
        cpu_req_valid_i = 1'b0; cpu_addr_i = 32'h0; cpu_we_i = 1'b0;
        mem_req_ready_i = 1'b0; mem_beat_i = 1'b0;
        clear_model();
        repeat (3) @(negedge clk_i);
        chk("rst_ready", cpu_req_ready_o, 1'b0);
        chk("rst_resp", cpu_resp_valid_o, 1'b0);
        chk("rst_cmd_valid", mem_req_valid_o, 1'b0);
        chk("rst_wr_en", cache_req_o.wr_en, 1'b0);
        chk("rst_fill_we", dmem_fill_we_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ready", cpu_req_ready_o, 1'b1);

        run_txn(32'h0000_1230, 1'b0, 0, -1);   // cold miss: fill only
        run_txn(32'h0000_1234, 1'b0, -1, -1);  // load hit
        run_txn(32'h0000_1238, 1'b1, -1, -1);  // store hit marks dirty
        run_txn(32'h0000_5230, 1'b0, -1, -1);  // dirty conflict: writeback + fill
`ifdef CACHE_STATS_EN
        chk("stats_hits", hit_cnt_o, 32'd2);
        chk("stats_misses", miss_cnt_o, 32'd2);
`endif
        run_txn(32'h0000_9230, 1'b0, 5, 2);    // stalled command, reset after 2 beats

        for (int n = 0; n < 120; n++) begin
            run_txn({r_tags[$urandom_range(0, 3)], r_idxs[$urandom_range(0, 3)],
                     4'($urandom_range(0, 15))}, 1'($urandom_range(0, 1)), -1, -1);
        end
`ifdef CACHE_STATS_EN
        chk("final_hits", hit_cnt_o, 32'(m_hits));
        chk("final_misses", miss_cnt_o, 32'(m_misses));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
